// File: rtl/prng_lottery_arbiter_if.sv
// rtl/prng_lottery_arbiter_if.sv - request/grant bundle for the randomised lottery arbiter
interface prng_lottery_arbiter_if #(
    parameter int NREQ = 16
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic            seed_ld;
    logic [31:0]     seed_val;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;
    logic            timeout;

    modport master (
        output req, seed_ld, seed_val,
        input  gnt, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req, seed_ld, seed_val,
        output gnt, gnt_valid, gnt_id, timeout
    );
endinterface

// File: rtl/prng_lottery_arbiter.sv
// rtl/prng_lottery_arbiter.sv - LFSR-seeded rotating-start arbiter with hold timeout and one-shot skip mask
module prng_lottery_arbiter #(
    parameter int          NREQ     = 16,
    parameter int          MAX_HOLD = 64,
    parameter logic [31:0] SEED     = 32'hAAAAAAAA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prng_lottery_arbiter_if.slave  bus
);
    localparam int          IW   = $clog2(NREQ);
    localparam int          HW   = $clog2(MAX_HOLD);
    localparam logic [31:0] TAPS = 32'hB89ADA1C;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [31:0]     lfsr, lfsr_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [NREQ-1:0] mask, mask_nxt;
    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [IW-1:0]   gnt_id_q, id_nxt;
    logic            timeout_q, to_nxt;

    logic [NREQ-1:0] eff_req;
    logic [IW-1:0]   start, cand, win_id;
    logic            win_found;
    logic            owner_gone, hold_done;

    assign start      = lfsr[IW-1:0];
    assign owner_gone = !bus.req[gnt_id_q];
    assign hold_done  = (hold_cnt == HW'(MAX_HOLD - 1));

    always_comb begin
        lfsr_nxt = {lfsr[30:0], ^(lfsr & TAPS)};
        if (bus.seed_ld)
            lfsr_nxt = (bus.seed_val == 32'd0) ? SEED : bus.seed_val;
    end

    // A lone masked requester must still win, otherwise it would starve.
    always_comb begin
        eff_req = bus.req & ~mask;
        if (eff_req == '0)
            eff_req = bus.req;
    end

    // Reverse scan so the closest index at/after start is assigned last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = start + IW'(k);
            if (eff_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED;
            hold_cnt  <= '0;
            mask      <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            hold_cnt  <= hold_nxt;
            mask      <= mask_nxt;
            gnt_q     <= gnt_nxt;
            gnt_id_q  <= id_nxt;
            timeout_q <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if (owner_gone || hold_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = '0;
        id_nxt   = '0;
        to_nxt   = 1'b0;
        hold_nxt = hold_cnt;
        mask_nxt = mask;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt[win_id] = 1'b1;
                    id_nxt          = win_id;
                    hold_nxt        = '0;
                    mask_nxt        = '0;
                end
            end
            GRANT: begin
                if (owner_gone) begin
                    gnt_nxt = '0;
                end else if (hold_done) begin
                    to_nxt             = 1'b1;
                    mask_nxt           = '0;
                    mask_nxt[gnt_id_q] = 1'b1;
                end else begin
                    gnt_nxt  = gnt_q;
                    id_nxt   = gnt_id_q;
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.timeout   = timeout_q;
endmodule
